// File: rtl/traffic_pkg.sv
// traffic_pkg: shared types and constants for the two-road traffic light
// phase controller.
//   state_t  - controller states (3-bit encoding)
//   phase_t  - countdown phase class used by the BCD display helper
//   lamps_t  - {main, side} lamp triplets, each {red, yellow, green}
//   lamps_for() / phase_of() - decode a state into lamps / countdown class
package traffic_pkg;

  typedef enum logic [2:0] {
    ST_START = 3'd0,
    ST_MG    = 3'd1,
    ST_MY    = 3'd2,
    ST_SG    = 3'd3,
    ST_SY    = 3'd4,
    ST_FLASH = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    PH_NONE   = 2'd0,
    PH_GREEN  = 2'd1,
    PH_YELLOW = 2'd2
  } phase_t;

  localparam logic [2:0] L_RED = 3'b100;
  localparam logic [2:0] L_YEL = 3'b010;
  localparam logic [2:0] L_GRN = 3'b001;
  localparam logic [2:0] L_OFF = 3'b000;

  localparam int DEF_GREEN_S  = 30;
  localparam int DEF_YELLOW_S = 3;

  typedef struct packed {
    logic [2:0] main;
    logic [2:0] side;
  } lamps_t;

  // Lamp pattern shown while in state s; flash_on selects the lit half of
  // the night-mode yellow blink.
  function automatic lamps_t lamps_for(state_t s, logic flash_on);
    lamps_t l;
    l.main = L_RED;
    l.side = L_RED;
    case (s)
      ST_MG:    begin l.main = L_GRN; l.side = L_RED; end
      ST_MY:    begin l.main = L_YEL; l.side = L_RED; end
      ST_SG:    begin l.main = L_RED; l.side = L_GRN; end
      ST_SY:    begin l.main = L_RED; l.side = L_YEL; end
      ST_FLASH: begin
        l.main = flash_on ? L_YEL : L_OFF;
        l.side = flash_on ? L_YEL : L_OFF;
      end
      default:  begin l.main = L_RED; l.side = L_RED; end
    endcase
    return l;
  endfunction

  function automatic phase_t phase_of(state_t s);
    phase_t p;
    case (s)
      ST_MG, ST_SG: p = PH_GREEN;
      ST_MY, ST_SY: p = PH_YELLOW;
      default:      p = PH_NONE;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/traffic_fsm_if.sv
// traffic_fsm_if: bundle between the phase controller and its surroundings
// (interval counter, night request, lamp drivers, display stage).
//   master - environment side: drives counter flags/count and night,
//            observes sc, lamps and countdown digits
//   slave  - the phase controller itself
interface traffic_fsm_if;
  logic       t_30;
  logic       t_3;
  logic [4:0] count_i;
  logic       night;
  logic       sc;
  logic [2:0] main_l;
  logic [2:0] side_l;
  logic [3:0] remain_tens;
  logic [3:0] remain_ones;

  modport master (
    output t_30, t_3, count_i, night,
    input  sc, main_l, side_l, remain_tens, remain_ones
  );

  modport slave (
    input  t_30, t_3, count_i, night,
    output sc, main_l, side_l, remain_tens, remain_ones
  );
endinterface

// File: rtl/traffic_fsm_remain_bcd.sv
// remain_bcd: combinational countdown for the display stage.
//   phase in  - which phase length applies (green, yellow, none)
//   count in  - elapsed seconds from the interval counter (0..31)
//   tens  out - BCD tens of the saturated remaining seconds
//   ones  out - BCD ones of the saturated remaining seconds
module remain_bcd
  import traffic_pkg::*;
#(
  parameter int GREEN_S  = DEF_GREEN_S,
  parameter int YELLOW_S = DEF_YELLOW_S
) (
  input  phase_t     phase,
  input  logic [4:0] count,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  logic [5:0] len;
  logic [4:0] rem;

  always_comb begin
    len  = 6'd0;
    rem  = 5'd0;
    tens = 4'd0;
    ones = 4'd0;
    case (phase)
      PH_GREEN:  len = 6'(GREEN_S);
      PH_YELLOW: len = 6'(YELLOW_S);
      default:   len = 6'd0;
    endcase
    // Saturate at zero when the counter runs past the phase length.
    if (len > {1'b0, count}) begin
      rem = 5'(len - {1'b0, count});
    end
    // Remaining never exceeds 31, so three compares cover the tens digit.
    if (rem >= 5'd30) begin
      tens = 4'd3;
      ones = 4'(rem - 5'd30);
    end else if (rem >= 5'd20) begin
      tens = 4'd2;
      ones = 4'(rem - 5'd20);
    end else if (rem >= 5'd10) begin
      tens = 4'd1;
      ones = 4'(rem - 5'd10);
    end else begin
      tens = 4'd0;
      ones = 4'(rem);
    end
  end

endmodule

// File: rtl/traffic_fsm.sv
// traffic_fsm: phase controller for a two-road traffic light.
//   clk100M in - sole clock
//   rst     in - asynchronous active-high reset
//   bus  slave - t_30/t_3/count_i from the interval counter, night request;
//                sc restart pulse, main_l/side_l lamps {R,Y,G},
//                remain_tens/remain_ones BCD countdown
// Cycles START -> MG -> MY -> SG -> SY -> MG on counter timeouts, with a
// night-mode yellow flash. Every state change emits a one-cycle sc.
module traffic_fsm
  import traffic_pkg::*;
#(
  parameter int FLASH_DIV = 50_000_000,
  parameter int GREEN_S   = DEF_GREEN_S,
  parameter int YELLOW_S  = DEF_YELLOW_S
) (
  input  logic          clk100M,
  input  logic          rst,
  traffic_fsm_if.slave  bus
);

  localparam int DIV_W = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FLASH_DIV - 1);

  state_t           state_reg, state_next;
  logic             sc_reg, sc_next;
  logic             sc_hold_reg;
  logic [DIV_W-1:0] div_reg, div_next;
  logic             flash_on_reg, flash_on_next;
  lamps_t           lamps_reg, lamps_next;
  logic [3:0]       tens_reg, ones_reg;
  logic [3:0]       tens_calc, ones_calc;
  phase_t           cur_phase;
  logic             flags_live;
  logic             t30_live, t3_live;

  // The counter flags still reflect the old interval for the sc cycle and
  // the one after it; ignore them there so one timeout advances only once.
  assign flags_live = !sc_reg && !sc_hold_reg;
  assign t30_live   = bus.t_30 && flags_live;
  assign t3_live    = bus.t_3  && flags_live;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_START: state_next = ST_MG;
      ST_MG:    if (t30_live) state_next = ST_MY;
      ST_MY:    if (t3_live)  state_next = ST_SG;
      ST_SG:    if (t30_live) state_next = ST_SY;
      ST_SY:    if (t3_live)  state_next = ST_MG;
      ST_FLASH: if (!bus.night) state_next = ST_MG;
      default:  state_next = ST_START;
    endcase
    // Night overrides any timeout taken above.
    if (bus.night && state_reg != ST_START && state_reg != ST_FLASH) begin
      state_next = ST_FLASH;
    end
    sc_next = (state_next != state_reg);
  end

  // Blink timing: entering FLASH restarts the divider with the lamps lit,
  // so the first lit half-period is a full FLASH_DIV cycles.
  always_comb begin
    div_next      = '0;
    flash_on_next = 1'b0;
    if (state_next == ST_FLASH) begin
      if (state_reg != ST_FLASH) begin
        div_next      = '0;
        flash_on_next = 1'b1;
      end else if (div_reg == DIV_LAST) begin
        div_next      = '0;
        flash_on_next = !flash_on_reg;
      end else begin
        div_next      = div_reg + 1'b1;
        flash_on_next = flash_on_reg;
      end
    end
  end

  // Lamps are decoded from the next state so they update together with it.
  assign lamps_next = lamps_for(state_next, flash_on_next);
  assign cur_phase  = phase_of(state_reg);

  remain_bcd #(
    .GREEN_S  (GREEN_S),
    .YELLOW_S (YELLOW_S)
  ) u_remain_bcd (
    .phase (cur_phase),
    .count (bus.count_i),
    .tens  (tens_calc),
    .ones  (ones_calc)
  );

  always_ff @(posedge clk100M or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_START;
      sc_reg       <= 1'b0;
      sc_hold_reg  <= 1'b0;
      div_reg      <= '0;
      flash_on_reg <= 1'b0;
      lamps_reg    <= '{main: L_RED, side: L_RED};
      tens_reg     <= 4'd0;
      ones_reg     <= 4'd0;
    end else begin
      state_reg    <= state_next;
      sc_reg       <= sc_next;
      sc_hold_reg  <= sc_reg;
      div_reg      <= div_next;
      flash_on_reg <= flash_on_next;
      lamps_reg    <= lamps_next;
      tens_reg     <= tens_calc;
      ones_reg     <= ones_calc;
    end
  end

  assign bus.sc          = sc_reg;
  assign bus.main_l      = lamps_reg.main;
  assign bus.side_l      = lamps_reg.side;
  assign bus.remain_tens = tens_reg;
  assign bus.remain_ones = ones_reg;

endmodule

// File: tb/tb_traffic_fsm.sv
// Bench for traffic_fsm: directed literal checks plus randomized stimulus,
// with a phase-table reference model compared on every falling edge.
module tb_traffic_fsm;

  localparam int FDIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  traffic_fsm_if bus ();

  traffic_fsm #(
    .FLASH_DIV (FDIV),
    .GREEN_S   (30),
    .YELLOW_S  (3)
  ) dut (
    .clk100M (clk),
    .rst     (rst),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;
  int sc_seen  = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
    end
  endtask

  // Reference model. Phases: 0 START, 1 MG, 2 MY, 3 SG, 4 SY, 5 FLASH.
  logic [2:0] main_tab [6] = '{3'b100, 3'b001, 3'b010, 3'b100, 3'b100, 3'b000};
  logic [2:0] side_tab [6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b000};
  int         len_tab  [6] = '{0, 30, 3, 30, 3, 0};

  int m_ph    = 0;
  int m_since = 2;   // cycles since the last phase change (0 = sc visible)
  int m_fl    = 0;   // cycles spent in the current phase
  logic [3:0] m_tens = 4'd0;
  logic [3:0] m_ones = 4'd0;

  task automatic model_step();
    int np;
    int rem;
    bit live;
    if (rst) begin
      m_ph = 0; m_since = 2; m_fl = 0; m_tens = 4'd0; m_ones = 4'd0;
    end else begin
      rem = len_tab[m_ph] - int'(bus.count_i);
      if (rem < 0) rem = 0;
      m_tens = 4'(rem / 10);
      m_ones = 4'(rem % 10);
      live = (m_since >= 2);
      np = m_ph;
      if (m_ph == 0) np = 1;
      else if (bus.night) np = 5;
      else if (m_ph == 5) np = 1;
      else if (m_ph == 1 && bus.t_30 && live) np = 2;
      else if (m_ph == 2 && bus.t_3  && live) np = 3;
      else if (m_ph == 3 && bus.t_30 && live) np = 4;
      else if (m_ph == 4 && bus.t_3  && live) np = 1;
      if (np != m_ph) begin
        m_since = 0;
        m_fl = 0;
      end else begin
        if (m_since < 2) m_since++;
        m_fl++;
      end
      m_ph = np;
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  // Per-cycle comparison against the model.
  initial forever begin
    logic [2:0] em, es;
    @(negedge clk);
    cyc++;
    if (m_ph == 5) begin
      em = (((m_fl / FDIV) % 2) == 0) ? 3'b010 : 3'b000;
      es = em;
    end else begin
      em = main_tab[m_ph];
      es = side_tab[m_ph];
    end
    check("model_sc",   {7'd0, bus.sc}, {7'd0, (m_since == 0)});
    check("model_main", {5'd0, bus.main_l}, {5'd0, em});
    check("model_side", {5'd0, bus.side_l}, {5'd0, es});
    check("model_tens", {4'd0, bus.remain_tens}, {4'd0, m_tens});
    check("model_ones", {4'd0, bus.remain_ones}, {4'd0, m_ones});
    if (bus.sc === 1'b1) begin
      sc_seen++;
      $display("cycle %0d: sc, main=%b side=%b", cyc, bus.main_l, bus.side_l);
    end
  end

  // One timeout pulse, then check the new lamps and sc, then let the mask expire.
  task automatic step(input bit use30, input logic [2:0] wm, input logic [2:0] ws, input string tag);
    if (use30) bus.t_30 = 1'b1; else bus.t_3 = 1'b1;
    @(negedge clk);
    bus.t_30 = 1'b0;
    bus.t_3  = 1'b0;
    #1;
    check({tag, "_main"}, {5'd0, bus.main_l}, {5'd0, wm});
    check({tag, "_side"}, {5'd0, bus.side_l}, {5'd0, ws});
    check({tag, "_sc"},   {7'd0, bus.sc}, 8'd1);
    repeat (2) @(negedge clk);
  endtask

  logic [2:0] loop_main [4] = '{3'b010, 3'b100, 3'b100, 3'b001};
  logic [2:0] loop_side [4] = '{3'b100, 3'b001, 3'b010, 3'b100};

  initial begin
    int c0;
    bus.t_30 = 1'b0; bus.t_3 = 1'b0; bus.count_i = 5'd0; bus.night = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Reset release: START, then MG with sc, then display 30.
    rst = 1'b0;
    #1;
    check("start_main", {5'd0, bus.main_l}, 8'd4);
    check("start_sc",   {7'd0, bus.sc}, 8'd0);
    @(negedge clk);
    check("mg_sc",   {7'd0, bus.sc}, 8'd1);
    check("mg_main", {5'd0, bus.main_l}, 8'd1);
    check("mg_side", {5'd0, bus.side_l}, 8'd4);
    @(negedge clk);
    check("disp30_tens", {4'd0, bus.remain_tens}, 8'd3);
    check("disp30_ones", {4'd0, bus.remain_ones}, 8'd0);
    bus.count_i = 5'd12;
    @(negedge clk);
    check("disp18_tens", {4'd0, bus.remain_tens}, 8'd1);
    check("disp18_ones", {4'd0, bus.remain_ones}, 8'd8);

    // t_30 into MY, then hold t_30 through the masked cycles.
    bus.t_30 = 1'b1;
    @(negedge clk);
    check("my_main", {5'd0, bus.main_l}, 8'd2);
    check("my_sc",   {7'd0, bus.sc}, 8'd1);
    bus.count_i = 5'd0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("my_hold_main", {5'd0, bus.main_l}, 8'd2);
      check("my_hold_sc",   {7'd0, bus.sc}, 8'd0);
      if (k == 0) begin
        check("disp3_tens", {4'd0, bus.remain_tens}, 8'd0);
        check("disp3_ones", {4'd0, bus.remain_ones}, 8'd3);
      end
    end
    bus.t_30 = 1'b0;
    @(negedge clk);

    // Walk back to MG, then one full loop counting sc pulses.
    step(1'b0, 3'b100, 3'b001, "to_sg");
    step(1'b1, 3'b100, 3'b010, "to_sy");
    step(1'b0, 3'b001, 3'b100, "to_mg");
    c0 = sc_seen;
    for (int k = 0; k < 4; k++) begin
      step(k % 2 == 0, loop_main[k], loop_side[k], "loop");
    end
    check("loop_sc_count", 8'(sc_seen - c0), 8'd4);

    // Night with a simultaneous t_30: FLASH wins.
    bus.night = 1'b1;
    bus.t_30  = 1'b1;
    @(negedge clk);
    bus.t_30 = 1'b0;
    check("flash_sc",   {7'd0, bus.sc}, 8'd1);
    check("flash_main", {5'd0, bus.main_l}, 8'd2);
    check("flash_side", {5'd0, bus.side_l}, 8'd2);
    repeat (3) @(negedge clk);
    check("flash_still_on", {5'd0, bus.main_l}, 8'd2);
    @(negedge clk);
    check("flash_off_main", {5'd0, bus.main_l}, 8'd0);
    check("flash_off_side", {5'd0, bus.side_l}, 8'd0);
    repeat (4) @(negedge clk);
    check("flash_on_again", {5'd0, bus.main_l}, 8'd2);
    repeat (3) @(negedge clk);
    bus.night = 1'b0;
    @(negedge clk);
    check("night_exit_sc",   {7'd0, bus.sc}, 8'd1);
    check("night_exit_main", {5'd0, bus.main_l}, 8'd1);
    repeat (2) @(negedge clk);

    // Async reset in the middle of SG.
    step(1'b1, 3'b010, 3'b100, "rs_my");
    step(1'b0, 3'b100, 3'b001, "rs_sg");
    bus.count_i = 5'd5;
    repeat (2) @(negedge clk);
    check("sg_disp_tens", {4'd0, bus.remain_tens}, 8'd2);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_main", {5'd0, bus.main_l}, 8'd4);
    check("arst_side", {5'd0, bus.side_l}, 8'd4);
    check("arst_sc",   {7'd0, bus.sc}, 8'd0);
    check("arst_tens", {4'd0, bus.remain_tens}, 8'd0);
    check("arst_ones", {4'd0, bus.remain_ones}, 8'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_start_main", {5'd0, bus.main_l}, 8'd4);
    @(negedge clk);
    check("rel_mg_sc",   {7'd0, bus.sc}, 8'd1);
    check("rel_mg_main", {5'd0, bus.main_l}, 8'd1);

    // Randomized traffic with occasional night requests.
    for (int i = 0; i < 3000; i++) begin
      bus.t_30    = ($urandom_range(0, 5) == 0);
      bus.t_3     = ($urandom_range(0, 5) == 0);
      bus.count_i = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 149) == 0) bus.night = !bus.night;
      @(negedge clk);
    end
    bus.night = 1'b0;
    bus.t_30  = 1'b0;
    bus.t_3   = 1'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
